grid_port_arbiter: RTL and testbench

Shares the single read/write port of the level grid memory (40×30 cells, 3-bit cell codes) between three requesters: renderer (client 0), enemy updater (client 1) and player updater (client 2). The arbiter grants one access at a time using round-robin priority, with an optional per-client lock so a read-modify-write sequence is not interleaved. It drives the grid memory's x/y/write/data pins directly, and sits between the game-logic FSMs and the grid RAM.

---
 rtl/grid_pkg.sv | 47 ++++
 rtl/grid_port_arbiter_if.sv | 40 ++++
 rtl/grid_rr_picker.sv | 46 ++++
 rtl/grid_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_grid_port_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
//------------------------------------------------------------------------------
// grid_pkg : shared constants, cell codes, client ids and arbiter FSM encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package grid_pkg;

  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int X_W       = 6;
  localparam int Y_W       = 5;
  localparam int CELL_W    = 3;
  localparam int N_CLIENTS = 3;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 3'd0;
  localparam logic [CELL_W-1:0] CELL_ENEMY = 3'd4;

  localparam logic [1:0] CLIENT_RENDER = 2'd0;
  localparam logic [1:0] CLIENT_ENEMY  = 2'd1;
  localparam logic [1:0] CLIENT_PLAYER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [N_CLIENTS-1:0] oh);
    logic [1:0] idx;
    idx = CLIENT_RENDER;
    if (oh[1]) idx = CLIENT_ENEMY;
    if (oh[2]) idx = CLIENT_PLAYER;
    return idx;
  endfunction

  // Client index 'step' positions after 'base', wrapping over the three clients.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input int step);
    int s;
    s = int'(base) + step;
    return 2'(s % N_CLIENTS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_port_arbiter_if.sv
//------------------------------------------------------------------------------
// grid_port_arbiter_if : client request bundle plus grid memory pins
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface grid_port_arbiter_if;
  import grid_pkg::*;

  logic [N_CLIENTS-1:0]        req;
  logic [N_CLIENTS-1:0]        lock;
  logic [N_CLIENTS*X_W-1:0]    req_x;
  logic [N_CLIENTS*Y_W-1:0]    req_y;
  logic [N_CLIENTS-1:0]        req_we;
  logic [N_CLIENTS*CELL_W-1:0] req_wdata;
  logic [N_CLIENTS-1:0]        grant;
  logic [N_CLIENTS-1:0]        ack;
  logic [CELL_W-1:0]           rdata;
  logic                        busy;
  logic [X_W-1:0]              grid_x;
  logic [Y_W-1:0]              grid_y;
  logic                        grid_write;
  logic [CELL_W-1:0]           grid_in;
  logic [CELL_W-1:0]           grid_out;

  // Requester/memory side.
  modport master (
    output req, lock, req_x, req_y, req_we, req_wdata, grid_out,
    input  grant, ack, rdata, busy, grid_x, grid_y, grid_write, grid_in
  );

  // Arbiter side.
  modport slave (
    input  req, lock, req_x, req_y, req_we, req_wdata, grid_out,
    output grant, ack, rdata, busy, grid_x, grid_y, grid_write, grid_in
  );

endinterface

`default_nettype wire

// File: rtl/grid_rr_picker.sv
//------------------------------------------------------------------------------
// grid_rr_picker : combinational round-robin winner select with lock override
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grid_rr_picker
  import grid_pkg::*;
(
  input  wire logic [N_CLIENTS-1:0] i_req,
  input  wire logic [1:0]           i_ptr,
  input  wire logic                 i_lock_hold,
  input  wire logic [1:0]           i_lock_owner,
  output      logic [N_CLIENTS-1:0] o_winner,
  output      logic                 o_valid
);

  logic [N_CLIENTS-1:0] w_win;
  logic                 w_found;
  logic [1:0]           w_idx;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (i_lock_hold && i_req[i_lock_owner]) begin
      w_win[i_lock_owner] = 1'b1;
      w_found             = 1'b1;
    end else begin
      // Search starts one past the last served client; the pointer itself is checked last.
      for (int k = 1; k <= N_CLIENTS; k++) begin
        w_idx = rr_next(i_ptr, k);
        if (!w_found && i_req[w_idx]) begin
          w_win[w_idx] = 1'b1;
          w_found      = 1'b1;
        end
      end
    end
  end

  assign o_winner = w_win;
  assign o_valid  = w_found;

endmodule

`default_nettype wire

// File: rtl/grid_port_arbiter.sv
//------------------------------------------------------------------------------
// grid_port_arbiter : round-robin sharing of the grid RAM port among three clients
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grid_port_arbiter
  import grid_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int GRID_W     = grid_pkg::GRID_W,
  parameter int GRID_H     = grid_pkg::GRID_H
) (
  input  wire logic          clock,
  input  wire logic          reset,
  grid_port_arbiter_if.slave io_bus
);

  arb_state_t           r_state;
  logic [N_CLIENTS-1:0] r_grant;
  logic [N_CLIENTS-1:0] r_ack;
  logic [CELL_W-1:0]    r_rdata;
  logic                 r_busy;
  logic [X_W-1:0]       r_grid_x;
  logic [Y_W-1:0]       r_grid_y;
  logic                 r_grid_write;
  logic [CELL_W-1:0]    r_grid_in;
  logic [1:0]           r_ptr;
  logic                 r_lock_hold;
  logic [1:0]           r_lock_owner;
  logic                 r_we;
  logic                 r_in_range;
  logic [1:0]           r_cnt;

  logic [N_CLIENTS-1:0] w_win;
  logic                 w_valid;
  logic [1:0]           w_idx;
  logic                 w_lock_hold;
  logic [X_W-1:0]       w_sel_x;
  logic [Y_W-1:0]       w_sel_y;
  logic                 w_sel_we;
  logic [CELL_W-1:0]    w_sel_wdata;
  logic                 w_sel_lock;
  logic                 w_sel_in_range;

  // The lock only matters while re-arbitrating in ACK; a fresh IDLE start is pure RR.
  assign w_lock_hold = r_lock_hold && (r_state == ST_ACK);

  grid_rr_picker u_picker (
    .i_req        (io_bus.req),
    .i_ptr        (r_ptr),
    .i_lock_hold  (w_lock_hold),
    .i_lock_owner (r_lock_owner),
    .o_winner     (w_win),
    .o_valid      (w_valid)
  );

  assign w_idx = onehot_to_idx(w_win);

  always_comb begin
    w_sel_x     = io_bus.req_x[X_W-1:0];
    w_sel_y     = io_bus.req_y[Y_W-1:0];
    w_sel_wdata = io_bus.req_wdata[CELL_W-1:0];
    w_sel_we    = io_bus.req_we[0];
    w_sel_lock  = io_bus.lock[0];
    case (w_idx)
      CLIENT_ENEMY: begin
        w_sel_x     = io_bus.req_x[2*X_W-1:X_W];
        w_sel_y     = io_bus.req_y[2*Y_W-1:Y_W];
        w_sel_wdata = io_bus.req_wdata[2*CELL_W-1:CELL_W];
        w_sel_we    = io_bus.req_we[1];
        w_sel_lock  = io_bus.lock[1];
      end
      CLIENT_PLAYER: begin
        w_sel_x     = io_bus.req_x[3*X_W-1:2*X_W];
        w_sel_y     = io_bus.req_y[3*Y_W-1:2*Y_W];
        w_sel_wdata = io_bus.req_wdata[3*CELL_W-1:2*CELL_W];
        w_sel_we    = io_bus.req_we[2];
        w_sel_lock  = io_bus.lock[2];
      end
      default: ;
    endcase
  end

  assign w_sel_in_range = (int'(w_sel_x) < GRID_W) && (int'(w_sel_y) < GRID_H);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_ack        <= '0;
      r_rdata      <= CELL_EMPTY;
      r_busy       <= 1'b0;
      r_grid_x     <= '0;
      r_grid_y     <= '0;
      r_grid_write <= 1'b0;
      r_grid_in    <= '0;
      r_ptr        <= CLIENT_PLAYER;
      r_lock_hold  <= 1'b0;
      r_lock_owner <= CLIENT_RENDER;
      r_we         <= 1'b0;
      r_in_range   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACK: begin
          r_ack <= '0;
          if (w_valid) begin
            r_state      <= ST_ISSUE;
            r_busy       <= 1'b1;
            r_grant      <= w_win;
            r_ptr        <= w_idx;
            r_lock_hold  <= w_sel_lock;
            r_lock_owner <= w_idx;
            r_we         <= w_sel_we;
            r_in_range   <= w_sel_in_range;
            r_grid_x     <= w_sel_x;
            r_grid_y     <= w_sel_y;
            r_grid_in    <= w_sel_wdata;
            r_grid_write <= w_sel_we && w_sel_in_range;
          end else begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_grant     <= '0;
            r_lock_hold <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_grid_write <= 1'b0;
          r_cnt        <= '0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == 2'(RD_LATENCY - 1)) begin
            r_rdata <= (r_we || !r_in_range) ? CELL_EMPTY : io_bus.grid_out;
            r_ack   <= r_grant;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.grant      = r_grant;
  assign io_bus.ack        = r_ack;
  assign io_bus.rdata      = r_rdata;
  assign io_bus.busy       = r_busy;
  assign io_bus.grid_x     = r_grid_x;
  assign io_bus.grid_y     = r_grid_y;
  assign io_bus.grid_write = r_grid_write;
  assign io_bus.grid_in    = r_grid_in;

endmodule

`default_nettype wire

// File: tb/tb_grid_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_grid_port_arbiter : vector table plus scoreboarded multi-client sequences
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_grid_port_arbiter;
  import grid_pkg::*;

  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_port_arbiter_if bus ();

  grid_port_arbiter #(
    .RD_LATENCY (RD_LAT),
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H)
  ) dut (
    .clock  (clk),
    .reset  (rst),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.grid_write) wr_cnt++;

  // Grid RAM model with RD_LAT = 1; (0,30) holds a non-empty code to expose a leaked read.
  logic [2:0] mem [64][32];
  logic [2:0] rd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd         <= '0;
      mem[5][7]  <= CELL_ENEMY;
      mem[0][30] <= 3'd5;
    end else begin
      if (bus.grid_write) mem[bus.grid_x][bus.grid_y] <= bus.grid_in;
      rd <= mem[bus.grid_x][bus.grid_y];
    end
  end
  assign bus.grid_out = rd;

  // Client models: each holds req until it has seen n_left acks.
  int         n_left [3];
  bit         lock_en[3];
  logic [5:0] cx     [3];
  logic [4:0] cy     [3];
  bit         cwe    [3];
  logic [2:0] cwd    [3];
  logic [2:0]  d_req, d_lock, d_we;
  logic [17:0] d_x;
  logic [14:0] d_y;
  logic [8:0]  d_wd;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (!rst && bus.ack[k] && n_left[k] > 0) n_left[k]--;
    for (int k = 0; k < 3; k++) begin
      d_req[k]          = (n_left[k] > 0);
      d_lock[k]         = lock_en[k] && d_req[k];
      d_we[k]           = cwe[k];
      d_x[6*k +: 6]     = cx[k];
      d_y[5*k +: 5]     = cy[k];
      d_wd[3*k +: 3]    = cwd[k];
    end
    bus.req       = d_req;
    bus.lock      = d_lock;
    bus.req_we    = d_we;
    bus.req_x     = d_x;
    bus.req_y     = d_y;
    bus.req_wdata = d_wd;
  end

  typedef struct {
    logic [2:0] ack;
    logic [2:0] rdata;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [2:0] d, input int c);
    exp_t e;
    e.ack = a; e.rdata = d; e.cyc = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ack != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", int'(bus.ack), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_onehot", int'(bus.ack), int'(mon_e.ack));
        chk("ack_rdata", int'(bus.rdata), int'(mon_e.rdata));
        chk("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic launch(input int k, input int n, input bit lk, input bit we,
                        input int x, input int y, input int wd);
    cx[k] = 6'(x); cy[k] = 5'(y); cwe[k] = we; cwd[k] = 3'(wd);
    lock_en[k] = lk;
    n_left[k]  = n;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy || n_left[0] > 0 || n_left[1] > 0 || n_left[2] > 0)
           && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n >= budget), 0);
    if (n >= budget) begin
      sb.delete();
      for (int k = 0; k < 3; k++) n_left[k] = 0;
    end
  endtask

  typedef struct {
    int client; bit we; int x; int y; int wdata; int exp_rdata; bit exp_write;
  } vec_t;
  vec_t vt[8];

  int t0, snap;

  initial begin
    for (int k = 0; k < 3; k++) begin
      n_left[k] = 0; lock_en[k] = 0; cx[k] = '0; cy[k] = '0; cwe[k] = 0; cwd[k] = '0;
    end
    vt[0] = '{1, 1'b0,  5,  7, 0, 4, 1'b0};
    vt[1] = '{2, 1'b1, 39, 29, 3, 0, 1'b1};
    vt[2] = '{0, 1'b0, 39, 29, 0, 3, 1'b0};
    vt[3] = '{0, 1'b1, 40,  0, 6, 0, 1'b0};
    vt[4] = '{0, 1'b0,  0, 30, 0, 0, 1'b0};
    vt[5] = '{1, 1'b1,  0,  0, 7, 0, 1'b1};
    vt[6] = '{2, 1'b0,  0,  0, 0, 7, 1'b0};
    vt[7] = '{0, 1'b0,  5,  7, 0, 4, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", int'({bus.grant, bus.ack, bus.rdata, bus.busy, bus.grid_x,
                               bus.grid_y, bus.grid_write, bus.grid_in}), 0);

    // Single accesses, one at a time.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      t0 = cyc; snap = wr_cnt;
      launch(vt[i].client, 1, 1'b0, vt[i].we, vt[i].x, vt[i].y, vt[i].wdata);
      push(3'(1 << vt[i].client), 3'(vt[i].exp_rdata), t0 + 2 + RD_LAT);
      @(posedge clk); #1;
      chk("issue_grant", int'(bus.grant), 1 << vt[i].client);
      chk("issue_grid_x", int'(bus.grid_x), vt[i].x % 64);
      chk("issue_grid_y", int'(bus.grid_y), vt[i].y % 32);
      chk("issue_grid_write", int'(bus.grid_write), int'(vt[i].exp_write));
      chk("issue_busy", int'(bus.busy), 1);
      wait_idle(20);
      chk("write_pulses", wr_cnt - snap, int'(vt[i].exp_write));
    end

    // Reset during WAIT: everything clears, the access never acks.
    @(posedge clk); #1;
    launch(1, 1, 1'b0, 1'b0, 5, 7, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    n_left[1] = 0;
    #1;
    chk("midreset_outputs", int'({bus.grant, bus.ack, bus.rdata, bus.busy, bus.grid_x,
                                  bus.grid_y, bus.grid_write, bus.grid_in}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle", int'({bus.busy, bus.ack}), 0);

    // After reset the pointer restarts with client 0 first.
    t0 = cyc;
    push(3'b001, 3'd4, t0 + 3);
    push(3'b010, 3'd0, t0 + 6);
    push(3'b100, 3'd3, t0 + 9);
    launch(0, 1, 1'b0, 1'b0, 5, 7, 0);
    launch(1, 1, 1'b0, 1'b1, 12, 12, 1);
    launch(2, 1, 1'b0, 1'b0, 39, 29, 0);
    wait_idle(40);

    // Continuous contention: strict rotation, no idle cycle between accesses.
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 6; i++) push(3'(1 << (i % 3)), 3'd0, t0 + 3 + 3 * i);
    launch(0, 2, 1'b0, 1'b1, 1, 1, 2);
    launch(1, 2, 1'b0, 1'b1, 2, 2, 2);
    launch(2, 2, 1'b0, 1'b1, 3, 3, 2);
    wait_idle(60);

    // Lock: client 1 keeps the port for three accesses, then RR resumes at 2.
    @(posedge clk); #1;
    t0 = cyc;
    push(3'b010, 3'd4, t0 + 3);
    push(3'b010, 3'd4, t0 + 6);
    push(3'b010, 3'd4, t0 + 9);
    push(3'b100, 3'd0, t0 + 12);
    push(3'b001, 3'd3, t0 + 15);
    launch(1, 3, 1'b1, 1'b0, 5, 7, 0);
    @(posedge clk); #1;
    launch(0, 1, 1'b0, 1'b0, 39, 29, 0);
    launch(2, 1, 1'b0, 1'b1, 10, 20, 5);
    wait_idle(60);
    lock_en[1] = 0;

    // Confirm the write made under contention landed.
    @(posedge clk); #1;
    t0 = cyc;
    push(3'b010, 3'd5, t0 + 3);
    launch(1, 1, 1'b0, 1'b0, 10, 20, 0);
    wait_idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

`default_nettype wire
